dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 29 ++
 rtl/dmem_responder_load_store_align.sv | 89 ++++++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared funct3 codes, FSM encoding and f3 legality helper
//
// Shared by the control path (dmem_responder) and the data path (load_store_align).

package dmem_responder_pkg;

    // RISC-V funct3 size/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Stores only know B/H/W; loads additionally know the unsigned variants.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        end
        return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W) &&
               (f3 != F3_BU) && (f3 != F3_HU);
    endfunction

endpackage

// File: rtl/dmem_responder_load_store_align.sv
// rtl/dmem_responder_load_store_align.sv - byte-lane alignment for loads and stores
//
// Ports:
//   we        in   1 = store, 0 = load
//   offset    in   byte offset within the word (addr[1:0])
//   f3        in   funct3 size/sign code
//   wdata     in   right-aligned store data
//   mem_word  in   current contents of the addressed word
//   be        out  byte enables for the store (0 for loads)
//   merged    out  mem_word with the enabled bytes replaced by store data
//   rdata     out  extracted and sign/zero-extended load data
//   misalign  out  halfword on an odd address or word on a non-zero offset

module load_store_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [2:0]  f3,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [3:0]  be,
    output logic [31:0] merged,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] lane_data;
    logic [31:0] shifted;

    always_comb begin
        misalign = 1'b0;
        case (f3[1:0])
            2'b01:   misalign = offset[0];
            2'b10:   misalign = (offset != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    // Store data is replicated across all lanes; the byte enables pick the live ones.
    always_comb begin
        be        = 4'b0000;
        lane_data = wdata;
        if (we) begin
            case (f3)
                F3_B: begin
                    be        = 4'b0001 << offset;
                    lane_data = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be        = 4'b0011 << offset;
                    lane_data = {2{wdata[15:0]}};
                end
                F3_W: begin
                    be        = 4'b1111;
                    lane_data = wdata;
                end
                default: begin
                    be        = 4'b0000;
                    lane_data = wdata;
                end
            endcase
        end
    end

    always_comb begin
        merged = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    assign shifted = mem_word >> {offset, 3'b000};

    always_comb begin
        rdata = 32'h0;
        case (f3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = mem_word;
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory responder with valid/ready handshakes
//
// Ports:
//   i_clk, i_rst (sync, active-low), i_clk_en (global step enable)
//   request:  i_req_valid / o_req_ready, i_req_we, i_req_addr, i_req_wdata, i_req_f3
//   response: o_rsp_valid / i_rsp_ready, o_rsp_rdata, o_rsp_err
//   o_busy    high whenever a transaction is in flight

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_f3,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [2:0]     r_f3;

    // Operands of the memory access; with no wait states the access happens
    // on the accept edge itself, so the live request is used.
    logic           a_we;
    logic [31:0]    a_addr;
    logic [31:0]    a_wdata;
    logic [2:0]     a_f3;

    always_comb begin
        a_we    = r_we;
        a_addr  = r_addr;
        a_wdata = r_wdata;
        a_f3    = r_f3;
        if (WAIT_CYCLES == 0) begin
            a_we    = i_req_we;
            a_addr  = i_req_addr;
            a_wdata = i_req_wdata;
            a_f3    = i_req_f3;
        end
    end

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       mem_word;
    logic [3:0]        be;
    logic [31:0]       merged;
    logic [31:0]       ld_data;
    logic              misalign;
    logic              out_of_range;
    logic              acc_err;
    logic [31:0]       result;
    logic              access;
    logic              do_write;

    assign word_idx = a_addr[ADDR_W+1:2];
    assign mem_word = mem[word_idx];

    load_store_align u_align (
        .we       (a_we),
        .offset   (a_addr[1:0]),
        .f3       (a_f3),
        .wdata    (a_wdata),
        .mem_word (mem_word),
        .be       (be),
        .merged   (merged),
        .rdata    (ld_data),
        .misalign (misalign)
    );

    assign out_of_range = |(a_addr >> (ADDR_W + 2));
    assign acc_err      = misalign | f3_illegal(a_we, a_f3) | out_of_range;
    assign result       = (acc_err || a_we) ? 32'h0 : ld_data;

    assign access = i_clk_en &&
                    (((state == ST_WAIT) && (cnt == '0)) ||
                     ((WAIT_CYCLES == 0) && (state == ST_IDLE) && i_req_valid));

    // Reset on the access edge still wins: the dropped store must not land.
    assign do_write = i_rst && access && a_we && !acc_err && (be != 4'b0000);

    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_f3        <= 3'b000;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h0;
            o_rsp_err   <= 1'b0;
            o_busy      <= 1'b0;
            o_req_ready <= 1'b1;
        end else if (i_clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_we        <= i_req_we;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_f3        <= i_req_f3;
                        o_busy      <= 1'b1;
                        o_req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state       <= ST_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= result;
                            o_rsp_err   <= acc_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state       <= ST_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= result;
                        o_rsp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        state       <= ST_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= 32'h0;
                        o_rsp_err   <= 1'b0;
                        o_busy      <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    o_busy      <= 1'b0;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder

module tb_dmem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int LAT         = WAIT_CYCLES + 1;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_f3 = 3'b000;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clk_en    (clk_en),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_f3    (req_f3),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] rd, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rdata = rd; v.exp_err = err;
        vecs.push_back(v);
    endfunction

    // Presents one request and returns just after the accept edge.
    task automatic send(input vec_t v, input bit push, input string name);
        exp_t e;
        @(negedge clk);
        check({name, " req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_f3    = v.f3;
        if (push) begin
            e.rdata = v.exp_rdata;
            e.err   = v.exp_err;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for the response, with clk_en held low for gap_len cycles right after accept.
    task automatic get_rsp(input int gap_len, input bit retire, input string name);
        int   en_edges;
        int   all_edges;
        logic en;
        exp_t e;
        en_edges  = 1;
        all_edges = 1;
        while (!rsp_valid && all_edges < 40) begin
            clk_en = (all_edges <= gap_len) ? 1'b0 : 1'b1;
            en = clk_en;
            @(posedge clk);
            #1;
            all_edges++;
            if (en) en_edges++;
        end
        clk_en = 1'b1;
        check({name, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({name, " latency"}, all_edges, LAT + gap_len);
        if (gap_len > 0) check({name, " enabled_latency"}, en_edges, LAT);
        if (exp_q.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            check({name, " rdata"}, rsp_rdata, e.rdata);
            check({name, " err"}, {31'h0, rsp_err}, {31'h0, e.err});
        end
        if (retire) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            check({name, " valid_drop"}, {31'h0, rsp_valid}, 32'h0);
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] held;

        add(1, 32'h10,   32'hDEADBEEF, LW,  32'h0,        0);
        add(0, 32'h10,   32'h0,        LW,  32'hDEADBEEF, 0);
        add(0, 32'h13,   32'h0,        LB,  32'hFFFFFFDE, 0);
        add(0, 32'h13,   32'h0,        LBU, 32'h000000DE, 0);
        add(0, 32'h12,   32'h0,        LHU, 32'h0000DEAD, 0);
        add(0, 32'h12,   32'h0,        LH,  32'hFFFFDEAD, 0);
        add(1, 32'h11,   32'hFFFFFF55, LB,  32'h0,        0);
        add(0, 32'h10,   32'h0,        LW,  32'hDEAD55EF, 0);
        add(0, 32'h12,   32'h0,        LW,  32'h0,        1);
        add(1, 32'h11,   32'h0000AAAA, LH,  32'h0,        1);
        add(0, 32'h1000, 32'h0,        LW,  32'h0,        1);
        add(0, 32'h10,   32'h0,        LW,  32'hDEAD55EF, 0);
        add(0, 32'h11,   32'h0,        LB,  32'h00000055, 0);
        add(0, 32'h10,   32'h0,        LH,  32'h000055EF, 0);
        add(1, 32'h12,   32'hFFFF1234, LH,  32'h0,        0);
        add(0, 32'h10,   32'h0,        LW,  32'h123455EF, 0);
        add(0, 32'h10,   32'h0,        3'b011, 32'h0,     1);
        add(1, 32'h10,   32'h000000FF, LBU, 32'h0,        1);
        add(0, 32'h10,   32'h0,        LW,  32'h123455EF, 0);
        add(0, 32'h13,   32'h0,        LH,  32'h0,        1);
        add(1, 32'h0,    32'hA5A5A5A5, LW,  32'h0,        0);
        add(1, 32'h1000, 32'h00000000, LW,  32'h0,        1);
        add(0, 32'h0,    32'h0,        LW,  32'hA5A5A5A5, 0);
        add(1, 32'hFFC,  32'h80000001, LW,  32'h0,        0);
        add(0, 32'hFFC,  32'h0,        LW,  32'h80000001, 0);
        add(1, 32'h20,   32'h11112222, LW,  32'h0,        0);
        add(0, 32'h20,   32'h0,        LW,  32'h11112222, 0);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset busy",      {31'h0, busy},      32'h0);
        check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset rdata",     rsp_rdata,          32'h0);
        check("reset err",       {31'h0, rsp_err},   32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i], 1'b1, $sformatf("v%0d", i));
            check($sformatf("v%0d busy", i), {31'h0, busy}, 32'h1);
            get_rsp(0, 1'b1, $sformatf("v%0d", i));
        end

        // Response held under backpressure, requests ignored, clk_en freezes RESP.
        v.we = 0; v.addr = 32'h10; v.wdata = 0; v.f3 = LW;
        v.exp_rdata = 32'h123455EF; v.exp_err = 0;
        send(v, 1'b1, "hold");
        get_rsp(0, 1'b0, "hold");
        held = 32'h123455EF;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d valid", k), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("hold%0d rdata", k), rsp_rdata, held);
            check($sformatf("hold%0d ready", k), {31'h0, req_ready}, 32'h0);
        end
        clk_en    = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("frozen resp valid", {31'h0, rsp_valid}, 32'h1);
        check("frozen resp rdata", rsp_rdata, held);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("release valid", {31'h0, rsp_valid}, 32'h0);
        check("release no_accept", {31'h0, busy}, 32'h0);
        req_valid = 1'b0;
        req_we    = 1'b0;

        // Two disabled cycles in WAIT stretch latency by two.
        send(v, 1'b1, "stretch");
        get_rsp(2, 1'b1, "stretch");

        // Reset on the would-be access edge of a store drops it.
        v.we = 1; v.addr = 32'h20; v.wdata = 32'h99999999; v.f3 = LW;
        send(v, 1'b0, "rst_sw");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sw busy",  {31'h0, busy},      32'h0);
        check("rst_sw ready", {31'h0, req_ready}, 32'h1);
        check("rst_sw valid", {31'h0, rsp_valid}, 32'h0);
        rst = 1'b1;
        v.we = 0; v.wdata = 0; v.exp_rdata = 32'h11112222; v.exp_err = 0;
        send(v, 1'b1, "after_rst");
        get_rsp(0, 1'b1, "after_rst");

        check("scoreboard drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
